// File: rtl/dm_responder_pkg.sv
// Shared types for the data-memory responder: FSM encoding and store-entry field widths.
package dm_responder_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dm_state_e;

  localparam int SB_DATA_W = 32;
  localparam int SB_STRB_W = 4;
  localparam int SB_PC_W   = 32;

endpackage

// File: rtl/dm_store_fifo.sv
// Circular store buffer; a push and a pop in the same cycle are accepted even when full.
module dm_store_fifo #(
  parameter int WIDTH    = 80,
  parameter int SB_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(SB_DEPTH);

  logic [WIDTH-1:0] entries [SB_DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(SB_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = entries[head_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) entries[tail_q] <= din;
  end

endmodule

// File: rtl/dm_responder.sv
// CPU data-port responder: zero-latency reads from a local word array, lane-masked stores
// mirrored write-through to a backing port via a small store buffer, zero-fill after reset.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH    = 3072,
  parameter int AW       = 12,
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        init_done,
  output logic        ext_wvalid,
  input  logic        ext_wready,
  output logic [31:0] ext_waddr,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_wstrb,
  output logic [31:0] ext_wpc,
  output logic        sb_overflow,
  output logic        addr_err
);

  typedef struct packed {
    logic [AW-1:0]        idx;
    logic [SB_DATA_W-1:0] data;
    logic [SB_STRB_W-1:0] strb;
    logic [SB_PC_W-1:0]   pc;
  } sb_entry_t;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

  logic [31:0] mem [DEPTH];

  dm_state_e   state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  logic [AW-1:0] idx;
  logic          in_range;
  logic          run;
  logic          store_req;
  logic          store_ok;
  logic          store_bad;
  logic          sb_pop;
  logic          sb_full;
  logic          sb_empty;
  sb_entry_t     sb_din;
  sb_entry_t     sb_dout;
  logic          unused_addr_bits;

  assign idx              = m_data_addr[AW+1:2];
  assign in_range         = ({1'b0, idx} < DEPTH_L);
  assign run              = (state_q == ST_RUN);
  assign store_req        = run && (m_data_byteen != 4'b0000);
  assign store_ok         = store_req && in_range;
  assign store_bad        = store_req && !in_range;
  assign unused_addr_bits = ^{m_data_addr[31:AW+2], m_data_addr[1:0]};

  assign init_done    = run;
  assign m_data_rdata = (run && in_range) ? mem[idx] : 32'h0000_0000;

  // Clear / run sequencing
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IX) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      sb_overflow <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      addr_err  <= store_bad;
      if (store_ok && sb_full && !sb_pop) sb_overflow <= 1'b1;
    end
  end

  // Local array: zero-fill during CLEAR, lane-masked store during RUN
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_idx_q] <= 32'h0000_0000;
    end else if (store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (m_data_byteen[i]) mem[idx][8*i +: 8] <= m_data_wdata[8*i +: 8];
      end
    end
  end

  // Write-through store buffer
  assign sb_din.idx  = idx;
  assign sb_din.data = m_data_wdata;
  assign sb_din.strb = m_data_byteen;
  assign sb_din.pc   = m_inst_addr;
  assign sb_pop      = ext_wvalid && ext_wready;

  dm_store_fifo #(
    .WIDTH    ($bits(sb_entry_t)),
    .SB_DEPTH (SB_DEPTH)
  ) u_store_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (store_ok),
    .pop   (sb_pop),
    .din   (sb_din),
    .dout  (sb_dout),
    .full  (sb_full),
    .empty (sb_empty)
  );

  assign ext_wvalid = !sb_empty;
  assign ext_waddr  = {{(30-AW){1'b0}}, sb_dout.idx, 2'b00};
  assign ext_wdata  = sb_dout.data;
  assign ext_wstrb  = sb_dout.strb;
  assign ext_wpc    = sb_dout.pc;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: reference word array plus a queue of expected backing-port writes.
module tb_dm_responder;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        init_done;
  logic        ext_wvalid;
  logic        ext_wready;
  logic [31:0] ext_waddr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_wstrb;
  logic [31:0] ext_wpc;
  logic        sb_overflow;
  logic        addr_err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] pc;
  } ent_t;

  ent_t        sbq[$];
  logic [31:0] mm [3072];
  int          checks = 0;
  int          errors = 0;
  int          npops  = 0;
  bit          exp_ovf = 1'b0;
  logic [31:0] pc_ctr = 32'h0040_0000;

  dm_responder dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .init_done     (init_done),
    .ext_wvalid    (ext_wvalid),
    .ext_wready    (ext_wready),
    .ext_waddr     (ext_waddr),
    .ext_wdata     (ext_wdata),
    .ext_wstrb     (ext_wstrb),
    .ext_wpc       (ext_wpc),
    .sb_overflow   (sb_overflow),
    .addr_err      (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [11:0] i;
    i = a[13:2];
    if (i >= 12'd3072) return 32'h0;
    return mm[i];
  endfunction

  task automatic model_clear();
    foreach (mm[k]) mm[k] = 32'h0;
    sbq.delete();
    exp_ovf = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic tick(input bit chk_rd);
    ent_t        e;
    ent_t        n;
    logic [11:0] i;
    bit          exp_err;
    #4;
    if (chk_rd) check("rdata", m_data_rdata, exp_rd(m_data_addr));
    check("wvalid", {31'b0, ext_wvalid}, {31'b0, sbq.size() != 0});
    if (sbq.size() != 0 && ext_wready) begin
      e = sbq.pop_front();
      npops++;
      check("waddr", ext_waddr, e.addr);
      check("wdata", ext_wdata, e.data);
      check("wstrb", {28'b0, ext_wstrb}, {28'b0, e.strb});
      check("wpc", ext_wpc, e.pc);
    end
    exp_err = 1'b0;
    if (m_data_byteen != 4'b0000) begin
      i = m_data_addr[13:2];
      if (i >= 12'd3072) begin
        exp_err = 1'b1;
      end else begin
        for (int b = 0; b < 4; b++)
          if (m_data_byteen[b]) mm[i][8*b +: 8] = m_data_wdata[8*b +: 8];
        n.addr = {18'b0, i, 2'b00};
        n.data = m_data_wdata;
        n.strb = m_data_byteen;
        n.pc   = m_inst_addr;
        if (sbq.size() < 4) sbq.push_back(n);
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
    check("sb_overflow", {31'b0, sb_overflow}, {31'b0, exp_ovf});
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    m_inst_addr   = pc_ctr;
    pc_ctr        = pc_ctr + 32'd4;
    tick(1'b1);
    m_data_byteen = 4'b0000;
  endtask

  task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    m_data_addr   = a;
    m_data_byteen = 4'b0000;
    #2;
    check(tag, m_data_rdata, exp);
    tick(1'b1);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, 3072);
    model_clear();
  endtask

  initial begin
    reset         = 1'b0;
    ext_wready    = 1'b0;
    m_data_addr   = 32'h0;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'b0000;
    m_inst_addr   = 32'h0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", {31'b0, init_done}, 32'h0);
    check("rst_wvalid", {31'b0, ext_wvalid}, 32'h0);
    check("rst_overflow", {31'b0, sb_overflow}, 32'h0);
    check("rst_addr_err", {31'b0, addr_err}, 32'h0);
    check("rst_rdata", m_data_rdata, 32'h0);
    reset = 1'b1;
    wait_init("init_cycles");

    // Top of array is zero after the fill
    read_expect("t1_top", 32'h0000_2FFC, 32'h0000_0000);

    // Full word, then a single-lane merge
    store(32'h10, 32'h1234_5678, 4'hF);
    store(32'h10, 32'h0000_AB00, 4'b0010);
    read_expect("t2_merge", 32'h10, 32'h1234_AB78);
    npops = 0;
    ext_wready = 1'b1;
    repeat (3) tick(1'b0);
    check("t2_drain", npops, 2);

    // Full buffer with simultaneous push and pop
    ext_wready = 1'b0;
    for (int k = 0; k < 4; k++) store(32'h80 + 32'(4*k), 32'hA000_0000 + 32'(k), 4'hF);
    ext_wready = 1'b1;
    store(32'h90, 32'hBEEF_0004, 4'hF);
    ext_wready = 1'b0;
    tick(1'b0);
    check("t4_no_ovf", {31'b0, sb_overflow}, 32'h0);
    npops = 0;
    ext_wready = 1'b1;
    repeat (6) tick(1'b0);
    check("t4_drain", npops, 4);

    // Out-of-range store
    store(32'h3000, 32'hDEAD_BEEF, 4'hF);
    tick(1'b0);
    read_expect("t5_rd", 32'h3000, 32'h0);

    // Overflow on the fifth queued store
    ext_wready = 1'b0;
    for (int k = 0; k < 5; k++) store(32'h20 + 32'(4*k), 32'h5500_0000 + 32'(k), 4'hF);
    check("t3_ovf", {31'b0, sb_overflow}, 32'h1);
    read_expect("t3_local5", 32'h30, 32'h5500_0004);
    npops = 0;
    ext_wready = 1'b1;
    repeat (8) tick(1'b0);
    check("t3_drain", npops, 4);

    // Mixed random traffic
    for (int k = 0; k < 60; k++) begin
      ext_wready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) store(32'h3004, $urandom, 4'hF);
      else store(32'h100 + 32'(4*$urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
    end
    ext_wready = 1'b1;
    repeat (6) tick(1'b0);
    check("rand_empty", {31'b0, ext_wvalid}, 32'h0);

    // Reset with entries queued, then a reset in the middle of the fill
    ext_wready = 1'b0;
    for (int k = 0; k < 3; k++) store(32'h40 + 32'(4*k), 32'h7700_0000 + 32'(k), 4'hF);
    check("t6_queued", {31'b0, ext_wvalid}, 32'h1);
    reset = 1'b0;
    #1;
    check("t6_wvalid_async", {31'b0, ext_wvalid}, 32'h0);
    check("t6_init_async", {31'b0, init_done}, 32'h0);
    model_clear();
    #1;
    reset = 1'b1;
    m_data_addr   = 32'h10;
    m_data_wdata  = 32'hFFFF_FFFF;
    m_data_byteen = 4'hF;
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    check("t6_mid_init", {31'b0, init_done}, 32'h0);
    check("t6_mid_rdata", m_data_rdata, 32'h0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    m_data_byteen = 4'b0000;
    wait_init("t6_refill_cycles");
    read_expect("t6_zeroed", 32'h10, 32'h0);
    read_expect("t6_zeroed_q", 32'h40, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
